// File: rtl/sa_feeder_pkg.sv
// Shared types and sizing helpers for the systolic-array skew feeder.
package sa_feeder_pkg;

  localparam int PE_SIZE_DEF    = 16;
  localparam int DATA_WIDTH_DEF = 8;

  typedef logic [DATA_WIDTH_DEF-1:0] lane_t;

  // Width able to hold the values 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane data+valid shift chain of DEPTH stages (DEPTH=0 is a wire); async active-high clear.
// No backpressure: shifts every cycle. Data behaviour on invalid stages follows SA_SKEW_FEEDER_ZERO_FILL_EN.
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  vld_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  vld_o,
  output logic                  busy_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign data_o = data_i;
    assign vld_o  = vld_i;
    assign busy_o = 1'b0;
  end else begin : g_chain
    logic [DEPTH-1:0]              vld_q;
    logic [DEPTH*DATA_WIDTH-1:0]   dat_q;
    // Index 0 is the chain input, index DEPTH the oldest stage (the lane output).
    logic [DEPTH:0]                vld_d;
    logic [(DEPTH+1)*DATA_WIDTH-1:0] dat_d;

    assign vld_d = {vld_q, vld_i};
    assign dat_d = {dat_q, data_i};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d[DEPTH-1:0];
        for (int j = 0; j < DEPTH; j++) begin
`ifdef SA_SKEW_FEEDER_ZERO_FILL_EN
          dat_q[j*DATA_WIDTH +: DATA_WIDTH] <= vld_d[j] ? dat_d[j*DATA_WIDTH +: DATA_WIDTH] : '0;
`else
          if (vld_d[j]) dat_q[j*DATA_WIDTH +: DATA_WIDTH] <= dat_d[j*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
      end
    end

    assign data_o = dat_d[DEPTH*DATA_WIDTH +: DATA_WIDTH];
    assign vld_o  = vld_d[DEPTH];
    assign busy_o = |vld_q;
  end

endmodule

// File: rtl/sa_skew_feeder.sv
// Row FIFO + diagonal skew into the systolic array; lane k valid k+1 cycles after the read edge.
// No backpressure: full drops writes (sticky overflow_o), empty ignores reads (sticky underflow_o).
// Optional SA_SKEW_FEEDER_ZERO_FILL_EN: invalid lanes drive zero instead of holding stale data.
module sa_skew_feeder
  import sa_feeder_pkg::*;
#(
  parameter  int PE_SIZE    = PE_SIZE_DEF,
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int FIFO_DEPTH = 16,
  localparam int ROW_WIDTH  = PE_SIZE * DATA_WIDTH,
  localparam int CW         = cnt_w(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wren_i,
  input  logic [ROW_WIDTH-1:0] wdata_i,
  input  logic                 rden_i,
  output logic [ROW_WIDTH-1:0] sa_data_o,
  output logic [PE_SIZE-1:0]   sa_valid_o,
  output logic [CW-1:0]        count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 busy_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int PW = ptr_w(FIFO_DEPTH);

  logic [ROW_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, udf_q;
  logic [ROW_WIDTH-1:0] launch_q;
  logic                 launch_vld_q;
  logic                 wr_acc, rd_acc;
  logic [PE_SIZE-1:0]   lane_busy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  // A same-cycle read frees the slot for the write; no bypass into an empty FIFO.
  assign wr_acc  = wren_i && (!full_o || rden_i);
  assign rd_acc  = rden_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = ptr_inc(wptr_q);
    if (rd_acc) rptr_d = ptr_inc(rptr_q);
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      launch_q     <= '0;
      launch_vld_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_q | (wren_i && !wr_acc);
      udf_q        <= udf_q | (rden_i && !rd_acc);
      launch_vld_q <= rd_acc;
      if (rd_acc) launch_q <= mem_q[rptr_q];
`ifdef SA_SKEW_FEEDER_ZERO_FILL_EN
      else        launch_q <= '0;
`endif
    end
  end

  for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
    skew_delay_line #(
      .DEPTH      (k),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_dly (
      .clk    (clk),
      .rst    (rst),
      .data_i (launch_q[k*DATA_WIDTH +: DATA_WIDTH]),
      .vld_i  (launch_vld_q),
      .data_o (sa_data_o[k*DATA_WIDTH +: DATA_WIDTH]),
      .vld_o  (sa_valid_o[k]),
      .busy_o (lane_busy[k])
    );
  end

  assign busy_o      = launch_vld_q | (|lane_busy);
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Randomised self-checking bench for sa_skew_feeder against a cycle-indexed launch-history model.
module tb_sa_skew_feeder;
  import sa_feeder_pkg::*;

  localparam int PE = 16;
  localparam int DW = 8;
  localparam int D  = 16;
  localparam int RW = PE * DW;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          wren_i, rden_i;
  logic [RW-1:0] wdata_i;
  logic [RW-1:0] sa_data_o;
  logic [PE-1:0] sa_valid_o;
  logic [CW-1:0] count_o;
  logic          full_o, empty_o, busy_o, overflow_o, underflow_o;

  always #5 clk = ~clk;

  sa_skew_feeder #(.PE_SIZE(PE), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .wren_i      (wren_i),
    .wdata_i     (wdata_i),
    .rden_i      (rden_i),
    .sa_data_o   (sa_data_o),
    .sa_valid_o  (sa_valid_o),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  int checks   = 0;
  int failures = 0;

  // Model: FIFO as a queue, plus a ring recording which row (if any) entered the launch
  // register at each cycle. Lane k in cycle c shows whatever launched in cycle c-k.
  logic [RW-1:0] q[$];
  bit            m_ovf, m_udf;
  bit            lv[32];
  logic [RW-1:0] lr[32];
  lane_t         last_val[PE];
  int            cyc = 100;
  logic [PE-1:0] e_vld;
  logic [RW-1:0] e_dat;
  bit            e_busy;

  function automatic logic [RW-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_eval();
    e_vld  = '0;
    e_busy = 1'b0;
    e_dat  = '0;
    for (int k = 0; k < PE; k++) begin
      int idx = (cyc - k) % 32;
      if (lv[idx]) begin
        e_vld[k]    = 1'b1;
        e_busy      = 1'b1;
        last_val[k] = lr[idx][k*DW +: DW];
      end
`ifdef SA_SKEW_FEEDER_ZERO_FILL_EN
      e_dat[k*DW +: DW] = e_vld[k] ? last_val[k] : '0;
`else
      e_dat[k*DW +: DW] = last_val[k];
`endif
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    for (int i = 0; i < 32; i++) begin
      lv[i] = 1'b0;
      lr[i] = '0;
    end
    for (int k = 0; k < PE; k++) last_val[k] = '0;
    model_eval();
  endfunction

  // Drive one cycle of stimulus at the negedge, advance the model, land on the next negedge.
  task automatic step(input bit we, input logic [RW-1:0] wd, input bit re);
    bit rd_ok, wr_ok;
    logic [RW-1:0] row;
    wren_i  = we;
    wdata_i = wd;
    rden_i  = re;
    rd_ok = re && (q.size() > 0);
    wr_ok = we && (q.size() < D || re);
    if (we && !wr_ok) m_ovf = 1'b1;
    if (re && !rd_ok) m_udf = 1'b1;
    row = '0;
    if (rd_ok) row = q.pop_front();
    if (wr_ok) q.push_back(wd);
    cyc++;
    lv[cyc % 32] = rd_ok;
    lr[cyc % 32] = row;
    @(posedge clk);
    @(negedge clk);
    model_eval();
  endtask

  task automatic do_reset();
    wren_i  = 1'b0;
    rden_i  = 1'b0;
    wdata_i = '0;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({sa_valid_o, busy_o, full_o, empty_o, overflow_o, underflow_o, count_o} !==
        {{PE{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {CW{1'b0}}}) begin
      failures++;
      $display("FAIL reset_flags got vld=%h busy=%b full=%b empty=%b ovf=%b udf=%b cnt=%0d",
               sa_valid_o, busy_o, full_o, empty_o, overflow_o, underflow_o, count_o);
    end
    checks++;
    if (sa_data_o !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", sa_data_o);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b0);
      checks++;
      if ({sa_valid_o, busy_o, empty_o, count_o} !== {{PE{1'b0}}, 1'b0, 1'b1, {CW{1'b0}}}) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got vld=%h busy=%b empty=%b cnt=%0d exp vld=0 busy=0 empty=1 cnt=0",
                 i, sa_valid_o, busy_o, empty_o, count_o);
      end
    end
  endtask

  // Fixed 4-row pattern checked directly against the wavefront formula rather than the model.
  task automatic test_diagonal();
    lane_t v;
    logic [PE-1:0] exp_v;
    int bad;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      v = lane_t'(8'h10 + r);
      step(1'b1, {PE{v}}, 1'b0);
      checks++;
      if (count_o !== CW'(r + 1)) begin
        failures++;
        $display("FAIL diag_count r=%0d got=%0d exp=%0d", r, count_o, r + 1);
      end
    end
    for (int s = 1; s <= 24; s++) begin
      step(1'b0, '0, s <= 4);
      exp_v = '0;
      bad   = 0;
      for (int k = 0; k < PE; k++) begin
        int d = s - 1 - k;
        if (d >= 0 && d <= 3) begin
          exp_v[k] = 1'b1;
          if (sa_data_o[k*DW +: DW] !== lane_t'(8'h10 + d)) bad++;
        end
      end
      checks++;
      if (sa_valid_o !== exp_v) begin
        failures++;
        $display("FAIL diag_valid s=%0d got=%h exp=%h", s, sa_valid_o, exp_v);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL diag_data s=%0d bad_lanes=%0d got=%h", s, bad, sa_data_o);
      end
      checks++;
      if (busy_o !== (s < 20)) begin
        failures++;
        $display("FAIL diag_busy s=%0d got=%b exp=%b", s, busy_o, s < 20);
      end
    end
  endtask

  task automatic test_overflow();
    int lane0_cnt;
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, rand_row(), 1'b0);
    checks++;
    if ({count_o, full_o, overflow_o, underflow_o} !== {CW'(16), 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL ovf_flags got cnt=%0d full=%b ovf=%b udf=%b exp cnt=16 full=1 ovf=1 udf=0",
               count_o, full_o, overflow_o, underflow_o);
    end
    lane0_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, '0, i < 17);
      if (sa_valid_o[0]) lane0_cnt++;
      checks++;
      if (sa_valid_o !== e_vld || sa_data_o !== e_dat) begin
        failures++;
        $display("FAIL ovf_drain i=%0d got vld=%h dat=%h exp vld=%h dat=%h", i, sa_valid_o, sa_data_o, e_vld, e_dat);
      end
    end
    checks++;
    if (lane0_cnt != 16) begin
      failures++;
      $display("FAIL ovf_rows_out got=%0d exp=16", lane0_cnt);
    end
    checks++;
    if ({empty_o, count_o, overflow_o, underflow_o} !== {1'b1, CW'(0), 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL ovf_sticky got empty=%b cnt=%0d ovf=%b udf=%b exp 1 0 1 1",
               empty_o, count_o, overflow_o, underflow_o);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b1, rand_row(), 1'b1);
    checks++;
    if ({underflow_o, overflow_o, count_o, empty_o, sa_valid_o, busy_o} !==
        {1'b1, 1'b0, CW'(1), 1'b0, {PE{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL udf_flags got udf=%b ovf=%b cnt=%0d empty=%b vld=%h busy=%b exp 1 0 1 0 0 0",
               underflow_o, overflow_o, count_o, empty_o, sa_valid_o, busy_o);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, i == 2);
      checks++;
      if (sa_valid_o !== e_vld || sa_data_o !== e_dat || busy_o !== e_busy || underflow_o !== 1'b1) begin
        failures++;
        $display("FAIL udf_drain i=%0d got vld=%h busy=%b udf=%b exp vld=%h busy=%b udf=1",
                 i, sa_valid_o, busy_o, underflow_o, e_vld, e_busy);
      end
    end
  endtask

  task automatic test_full_stream();
    do_reset();
    for (int i = 0; i < D; i++) step(1'b1, rand_row(), 1'b0);
    for (int i = 0; i < 60; i++) begin
      step(i < 30, rand_row(), i < 46);
      checks++;
      if (sa_valid_o !== e_vld || sa_data_o !== e_dat || busy_o !== e_busy) begin
        failures++;
        $display("FAIL stream_data i=%0d got vld=%h dat=%h busy=%b exp vld=%h dat=%h busy=%b",
                 i, sa_valid_o, sa_data_o, busy_o, e_vld, e_dat, e_busy);
      end
      if (i < 30) begin
        checks++;
        if ({count_o, full_o, overflow_o} !== {CW'(16), 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL stream_full i=%0d got cnt=%0d full=%b ovf=%b exp 16 1 0", i, count_o, full_o, overflow_o);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, rand_row(), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sa_valid_o, busy_o, count_o} !== {{PE{1'b0}}, 1'b0, CW'(0)}) begin
      failures++;
      $display("FAIL midrst_async got vld=%h busy=%b cnt=%0d exp 0 0 0", sa_valid_o, busy_o, count_o);
    end
`ifdef SA_SKEW_FEEDER_ZERO_FILL_EN
    checks++;
    if (sa_data_o !== '0) begin
      failures++;
      $display("FAIL midrst_zero got=%h exp=0", sa_data_o);
    end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      step(i == 0, rand_row(), i == 10);
      checks++;
      if (sa_valid_o !== e_vld || sa_data_o !== e_dat || busy_o !== e_busy) begin
        failures++;
        $display("FAIL midrst_after i=%0d got vld=%h dat=%h exp vld=%h dat=%h", i, sa_valid_o, sa_data_o, e_vld, e_dat);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, rand_row(), $urandom_range(0, 99) < 50);
      checks++;
      if (sa_valid_o !== e_vld || sa_data_o !== e_dat || busy_o !== e_busy ||
          count_o !== CW'(q.size()) || full_o !== (q.size() == D) || empty_o !== (q.size() == 0) ||
          overflow_o !== m_ovf || underflow_o !== m_udf) begin
        failures++;
        $display("FAIL random i=%0d got vld=%h busy=%b cnt=%0d ovf=%b udf=%b exp vld=%h busy=%b cnt=%0d ovf=%b udf=%b",
                 i, sa_valid_o, busy_o, count_o, overflow_o, underflow_o, e_vld, e_busy, q.size(), m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    wren_i  = 1'b0;
    rden_i  = 1'b0;
    wdata_i = '0;
    @(negedge clk);
    test_reset();
    test_diagonal();
    test_overflow();
    test_underflow();
    test_full_stream();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
